// File: rtl/lut_access_if.sv
// lut_access_if: client, config and LUT-facing bus of the LUT access controller
interface lut_access_if #(parameter int AW = 4);
  localparam int DEPTH = 2**AW;
  logic cfg_start, cfg_bit, cfg_busy, cfg_done;
  logic req0, req1, gnt0, gnt1;
  logic [AW-1:0] addr0, addr1, lut_addr;
  logic rd_valid, rd_data, rd_id, lut_out;
  logic [DEPTH-1:0] lut_ram;
  modport slave(
    input cfg_start, cfg_bit, req0, addr0, req1, addr1, lut_out,
    output cfg_busy, cfg_done, gnt0, gnt1, rd_valid, rd_data, rd_id, lut_ram, lut_addr
  );
  modport master(
    output cfg_start, cfg_bit, req0, addr0, req1, addr1, lut_out,
    input cfg_busy, cfg_done, gnt0, gnt1, rd_valid, rd_data, rd_id, lut_ram, lut_addr
  );
endinterface

// File: rtl/lut_access_ctrl.sv
// lut_access_ctrl: serial image loader and round-robin lookup arbiter for a 16x1 LUT
module lut_access_ctrl #(parameter int AW = 4) (
  input logic clk,
  input logic rst,
  lut_access_if.slave bus
);
  localparam int DEPTH = 2**AW;
  typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;
  state_t st_q, st_d;
  logic [AW-1:0] cnt_q, cnt_d, lut_addr_q, lut_addr_d;
  logic [DEPTH-1:0] shadow_q, shadow_d, lut_ram_q, lut_ram_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, last_q, last_d;
  logic rd_valid_q, rd_valid_d, rd_data_q, rd_data_d, rd_id_q, rd_id_d;
  logic cfg_done_q, cfg_done_d, w;
  always_comb begin
    w = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    st_d = st_q;
    cnt_d = cnt_q;
    lut_addr_d = lut_addr_q;
    shadow_d = shadow_q;
    lut_ram_d = lut_ram_q;
    last_d = last_q;
    rd_data_d = rd_data_q;
    rd_id_d = rd_id_q;
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    rd_valid_d = 1'b0;
    cfg_done_d = 1'b0;
    case (st_q)
      IDLE: if (bus.cfg_start) begin
        st_d = LOAD;
        cnt_d = '0;
      end else if (bus.req0 || bus.req1) begin
        gnt0_d = ~w;
        gnt1_d = w;
        lut_addr_d = w ? bus.addr1 : bus.addr0;
        last_d = w;
        rd_id_d = w;
        st_d = READ;
      end
      LOAD: begin
        shadow_d[cnt_q] = bus.cfg_bit;
        cnt_d = cnt_q + 1'b1;
        // commit the whole image at once so lookups never observe a partial load
        if (&cnt_q) begin
          lut_ram_d = {bus.cfg_bit, shadow_q[DEPTH-2:0]};
          cfg_done_d = 1'b1;
          st_d = IDLE;
          cnt_d = '0;
        end
      end
      READ: begin
        rd_data_d = bus.lut_out;
        rd_valid_d = 1'b1;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      lut_addr_q <= '0;
      shadow_q <= '0;
      lut_ram_q <= '0;
      last_q <= 1'b1;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= 1'b0;
      rd_id_q <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      lut_addr_q <= lut_addr_d;
      shadow_q <= shadow_d;
      lut_ram_q <= lut_ram_d;
      last_q <= last_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
      rd_id_q <= rd_id_d;
      cfg_done_q <= cfg_done_d;
    end
  end
  assign bus.cfg_busy = st_q == LOAD;
  assign bus.cfg_done = cfg_done_q;
  assign bus.gnt0 = gnt0_q;
  assign bus.gnt1 = gnt1_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_id = rd_id_q;
  assign bus.lut_ram = lut_ram_q;
  assign bus.lut_addr = lut_addr_q;
endmodule

// File: tb/tb_lut_access_ctrl.sv
// tb_lut_access_ctrl: randomized scoreboard bench against an image/round-robin reference model
module tb_lut_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  lut_access_if #(.AW(4)) bus();
  lut_access_ctrl #(.AW(4)) dut(.clk(clk), .rst(rst), .bus(bus));
  assign bus.lut_out = bus.lut_ram[bus.lut_addr];
  typedef struct packed {logic id; logic data;} rd_t;
  rd_t exp_q[$];
  rd_t e_mon;
  logic [15:0] img;
  logic last;
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    chk("gnt_exclusive", 32'(bus.gnt0 & bus.gnt1), 0);
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid with empty scoreboard at %0t", $time);
      end else begin
        e_mon = exp_q.pop_front();
        chk("rd_id", 32'(bus.rd_id), 32'(e_mon.id));
        chk("rd_data", 32'(bus.rd_data), 32'(e_mon.data));
      end
    end
  end
  task automatic drain_grants(input logic w, input int n);
    for (int c = 0; c < 2*n; c++) begin
      @(negedge clk);
      chk("grant", 32'({bus.gnt1, bus.gnt0}), c == 0 ? (w ? 2 : 1) : c == 2 ? (w ? 1 : 2) : 0);
      if (bus.gnt0) bus.req0 = 1'b0;
      if (bus.gnt1) bus.req1 = 1'b0;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask
  task automatic lookup(input logic r0, input logic r1, input logic [3:0] a0, input logic [3:0] a1);
    logic w;
    @(negedge clk);
    bus.req0 = r0;
    bus.req1 = r1;
    bus.addr0 = a0;
    bus.addr1 = a1;
    w = (r0 && r1) ? ~last : r1;
    exp_q.push_back(rd_t'({w, img[w ? a1 : a0]}));
    if (r0 && r1) exp_q.push_back(rd_t'({~w, img[w ? a0 : a1]}));
    last = (r0 && r1) ? ~w : w;
    drain_grants(w, (r0 && r1) ? 2 : 1);
  endtask
  task automatic load(input logic [15:0] v, input logic started, input logic with_req, input logic [3:0] a1, input logic chain);
    if (!started) begin
      @(negedge clk);
      bus.cfg_start = 1'b1;
    end
    if (with_req) begin
      bus.req1 = 1'b1;
      bus.addr1 = a1;
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.cfg_start = 1'($urandom);
      bus.cfg_bit = v[i];
      if (!with_req) begin
        bus.req0 = 1'($urandom);
        bus.req1 = 1'($urandom);
        bus.addr0 = 4'($urandom);
        bus.addr1 = 4'($urandom);
      end
      chk("cfg_busy", 32'(bus.cfg_busy), 1);
      chk("load_gnt", 32'({bus.gnt1, bus.gnt0}), 0);
      chk("load_done_low", 32'(bus.cfg_done), 0);
      chk("load_ram_stable", 32'(bus.lut_ram), 32'(img));
    end
    @(negedge clk);
    bus.cfg_start = chain;
    bus.req0 = 1'b0;
    if (!with_req) bus.req1 = 1'b0;
    img = v;
    chk("cfg_done", 32'(bus.cfg_done), 1);
    chk("cfg_busy_end", 32'(bus.cfg_busy), 0);
    chk("lut_ram", 32'(bus.lut_ram), 32'(v));
    if (with_req) begin
      exp_q.push_back(rd_t'({1'b1, img[a1]}));
      last = 1'b1;
      drain_grants(1'b1, 1);
    end else if (!chain) begin
      @(negedge clk);
      chk("cfg_done_pulse", 32'(bus.cfg_done), 0);
    end
  endtask
  task automatic reset_mid_load(input logic [15:0] v);
    @(negedge clk);
    bus.cfg_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.cfg_start = 1'b0;
      bus.cfg_bit = v[i];
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    img = '0;
    last = 1'b1;
    chk("rst_cfg_busy", 32'(bus.cfg_busy), 0);
    chk("rst_cfg_done", 32'(bus.cfg_done), 0);
    chk("rst_lut_ram", 32'(bus.lut_ram), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_no_done", 32'({bus.cfg_done, bus.cfg_busy}), 0);
    end
  endtask
  initial begin
    logic [1:0] p;
    bus.cfg_start = 1'b0;
    bus.cfg_bit = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.addr0 = '0;
    bus.addr1 = '0;
    img = '0;
    last = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_ctrl", 32'({bus.cfg_busy, bus.cfg_done, bus.gnt0, bus.gnt1}), 0);
    chk("reset_rd", 32'({bus.rd_valid, bus.rd_data, bus.rd_id}), 0);
    chk("reset_lut_ram", 32'(bus.lut_ram), 0);
    chk("reset_lut_addr", 32'(bus.lut_addr), 0);
    load(16'hA5C3, 1'b0, 1'b0, 4'h0, 1'b0);
    lookup(1'b1, 1'b0, 4'h0, 4'h0);
    lookup(1'b1, 1'b1, 4'h2, 4'hF);
    lookup(1'b1, 1'b1, 4'h2, 4'hF);
    load(16'h0000, 1'b0, 1'b1, 4'h0, 1'b0);
    load(16'($urandom), 1'b0, 1'b0, 4'h0, 1'b1);
    load(16'($urandom), 1'b1, 1'b0, 4'h0, 1'b0);
    lookup(1'b1, 1'b1, 4'($urandom), 4'($urandom));
    reset_mid_load(16'hFFFF);
    lookup(1'b1, 1'b1, 4'($urandom), 4'($urandom));
    load(16'h5A3C, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 5) == 0)
        load(16'($urandom), 1'b0, 1'($urandom), 4'($urandom), 1'b0);
      else begin
        p = 2'($urandom_range(1, 3));
        lookup(p[0], p[1], 4'($urandom), 4'($urandom));
      end
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
